vx_timeit_unit: RTL and testbench

- Consumer of the commit stage's commit-to-CSR timing channel; sits in the CSR unit.
- Owns the timeit configuration: enable, start PC and end PC. Drives these back to the commit stage.
- Measures, per warp, the cycles spent between a committed start PC and a committed end PC. Also counts the completed intervals for each warp.
- Counts the threads committed while any warp is active. All results are exposed through a CSR read/write port.

---
 rtl/vx_timeit_pkg.sv | 24 ++
 rtl/vx_timeit_warp_ctr.sv | 72 +++++++
 rtl/vx_timeit_unit.sv | 186 ++++++++++++++++++
 tb/tb_vx_timeit_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_timeit_pkg.sv
// Shared definitions for the timeit unit: CSR indices, CTRL/STATUS bit positions, FSM states.
package vx_timeit_pkg;

    localparam logic [7:0] CSR_CTRL      = 8'h00;
    localparam logic [7:0] CSR_START     = 8'h01;
    localparam logic [7:0] CSR_END       = 8'h02;
    localparam logic [7:0] CSR_STATUS    = 8'h03;
    localparam logic [7:0] CSR_INSTR_LO  = 8'h04;
    localparam logic [7:0] CSR_INSTR_HI  = 8'h05;
    localparam logic [7:0] CSR_CYC_BASE  = 8'h10;
    localparam logic [7:0] CSR_INTV_BASE = 8'h30;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_CLR_BIT     = 1;
    localparam int STATUS_STATE_LSB = 16;
    localparam int STATUS_OVF_BIT   = 24;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2
    } timeit_state_e;

endpackage

// File: rtl/vx_timeit_warp_ctr.sv
// Per-warp timing counters: cycle counter, active falling-edge interval counter, hi-word shadow.
// TIMEIT_OVF_IRQ_EN adds the wrap output used by the sticky overflow flag.
module vx_timeit_warp_ctr #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        run,
    input  logic        clear,
    input  logic        lo_rd,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_intv,
    input  logic [31:0] wdata,
`ifdef TIMEIT_OVF_IRQ_EN
    output logic        wrap,
`endif
    output logic [31:0] cyc_lo,
    output logic [31:0] cyc_shadow,
    output logic [31:0] intv
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cyc;
    logic             prev_active;
    logic             fall;

    assign fall   = run && prev_active && !active;
    assign cyc_lo = cyc[31:0];

`ifdef TIMEIT_OVF_IRQ_EN
    assign wrap = run && active && (&cyc);
`endif

    // A CSR write to a counter takes precedence over that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc         <= '0;
            intv        <= '0;
            cyc_shadow  <= '0;
            prev_active <= 1'b0;
        end else begin
            prev_active <= active;
            if (clear) begin
                cyc        <= '0;
                intv       <= '0;
                cyc_shadow <= '0;
            end else begin
                if (wr_lo) begin
                    cyc[31:0] <= wdata;
                end else if (wr_hi) begin
                    cyc[CNT_W-1:32] <= wdata[HI_W-1:0];
                end else if (run && active) begin
                    cyc <= cyc + CNT_W'(1);
                end

                if (wr_intv) begin
                    intv <= wdata;
                end else if (fall && (intv != 32'hFFFF_FFFF)) begin
                    intv <= intv + 32'd1;
                end

                if (lo_rd) begin
                    cyc_shadow <= 32'(cyc[CNT_W-1:32]);
                end
            end
        end
    end

endmodule

// File: rtl/vx_timeit_unit.sv
// Timeit CSR block: owns enable/start/end config, per-warp cycle and interval counters, committed-thread count.
// TIMEIT_OVF_IRQ_EN adds a sticky counter-wrap flag (STATUS[24]) and the timeit_ovf_irq output.
module vx_timeit_unit
    import vx_timeit_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_WARPS = 4,
    parameter int CSIZE_W   = 3,
    parameter int CNT_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmt_valid,
    input  logic [CSIZE_W-1:0]   cmt_size,
    input  logic [NUM_WARPS-1:0] timeit_active,
    output logic                 timeit_enable,
    output logic [31:0]          timeit_start_addr,
    output logic [31:0]          timeit_end_addr,
    input  logic                 csr_wr_valid,
    input  logic                 csr_rd_valid,
    input  logic [7:0]           csr_addr,
    input  logic [31:0]          csr_wdata,
    output logic                 csr_rd_ready,
    output logic [31:0]          csr_rdata,
`ifdef TIMEIT_OVF_IRQ_EN
    output logic                 timeit_ovf_irq,
`endif
    output logic [1:0]           dbg_state
);

    if (CNT_W <= 32 || CNT_W > 64 || NUM_WARPS < 1 || NUM_WARPS > 16 || CORE_ID < 0) begin : g_bad_param
        $error("vx_timeit_unit: unsupported parameter set");
    end

    timeit_state_e    state, state_n;
    logic             ctrl_wr, clear, run, running;
    logic [CNT_W-1:0] instr, instr_sum;
    logic             instr_inc;
    logic [31:0]      instr_shadow;
    logic [31:0]      cyc_lo     [NUM_WARPS];
    logic [31:0]      cyc_shadow [NUM_WARPS];
    logic [31:0]      intv       [NUM_WARPS];
    logic [31:0]      rd_mux;

    // Any CTRL write applies its enable bit; clear is a one-shot side effect.
    assign ctrl_wr   = csr_wr_valid && (csr_addr == CSR_CTRL);
    assign clear     = ctrl_wr && csr_wdata[CTRL_CLR_BIT];
    assign run       = (state != ST_OFF);
    assign running   = (state == ST_RUNNING);
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        case (state)
            ST_OFF:     state_n = ST_OFF;
            ST_ARMED:   if (|timeit_active) state_n = ST_RUNNING;
            ST_RUNNING: if (~|timeit_active) state_n = ST_ARMED;
            default:    state_n = ST_OFF;
        endcase
        if (ctrl_wr) begin
            if (!csr_wdata[CTRL_EN_BIT]) begin
                state_n = ST_OFF;
            end else if (state == ST_OFF) begin
                state_n = ST_ARMED;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_OFF;
            timeit_enable     <= 1'b0;
            timeit_start_addr <= '0;
            timeit_end_addr   <= '0;
        end else begin
            state         <= state_n;
            timeit_enable <= (state_n != ST_OFF);
            if (csr_wr_valid && (csr_addr == CSR_START)) timeit_start_addr <= csr_wdata;
            if (csr_wr_valid && (csr_addr == CSR_END))   timeit_end_addr   <= csr_wdata;
        end
    end

    assign instr_inc = cmt_valid && running;
    assign instr_sum = instr + CNT_W'(cmt_size);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr        <= '0;
            instr_shadow <= '0;
        end else if (clear) begin
            instr        <= '0;
            instr_shadow <= '0;
        end else begin
            if (csr_wr_valid && (csr_addr == CSR_INSTR_LO)) begin
                instr[31:0] <= csr_wdata;
            end else if (csr_wr_valid && (csr_addr == CSR_INSTR_HI)) begin
                instr[CNT_W-1:32] <= csr_wdata[CNT_W-33:0];
            end else if (instr_inc) begin
                instr <= instr_sum;
            end
            if (csr_rd_valid && (csr_addr == CSR_INSTR_LO)) begin
                instr_shadow <= 32'(instr[CNT_W-1:32]);
            end
        end
    end

`ifdef TIMEIT_OVF_IRQ_EN
    logic [NUM_WARPS-1:0] cyc_wrap;
    logic                 instr_wrap;
    logic                 ovf_flag;

    // With a non-zero addend, the sum is smaller than the old value exactly when it wrapped.
    assign instr_wrap     = instr_inc && (instr_sum < instr);
    assign timeit_ovf_irq = ovf_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_flag <= 1'b0;
        end else if (clear) begin
            ovf_flag <= 1'b0;
        end else if (instr_wrap || (|cyc_wrap)) begin
            ovf_flag <= 1'b1;
        end
    end
`endif

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        vx_timeit_warp_ctr #(
            .CNT_W(CNT_W)
        ) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .active     (timeit_active[w]),
            .run        (run),
            .clear      (clear),
            .lo_rd      (csr_rd_valid && (csr_addr == 8'(CSR_CYC_BASE + 8'(2 * w)))),
            .wr_lo      (csr_wr_valid && (csr_addr == 8'(CSR_CYC_BASE + 8'(2 * w)))),
            .wr_hi      (csr_wr_valid && (csr_addr == 8'(CSR_CYC_BASE + 8'(2 * w + 1)))),
            .wr_intv    (csr_wr_valid && (csr_addr == 8'(CSR_INTV_BASE + 8'(w)))),
            .wdata      (csr_wdata),
`ifdef TIMEIT_OVF_IRQ_EN
            .wrap       (cyc_wrap[w]),
`endif
            .cyc_lo     (cyc_lo[w]),
            .cyc_shadow (cyc_shadow[w]),
            .intv       (intv[w])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            CSR_CTRL:     rd_mux[CTRL_EN_BIT] = run;
            CSR_START:    rd_mux = timeit_start_addr;
            CSR_END:      rd_mux = timeit_end_addr;
            CSR_STATUS: begin
                rd_mux[NUM_WARPS-1:0]           = timeit_active;
                rd_mux[STATUS_STATE_LSB +: 2]   = state;
`ifdef TIMEIT_OVF_IRQ_EN
                rd_mux[STATUS_OVF_BIT]          = ovf_flag;
`endif
            end
            CSR_INSTR_LO: rd_mux = instr[31:0];
            CSR_INSTR_HI: rd_mux = instr_shadow;
            default: begin
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (csr_addr == 8'(CSR_CYC_BASE + 8'(2 * w)))     rd_mux = cyc_lo[w];
                    if (csr_addr == 8'(CSR_CYC_BASE + 8'(2 * w + 1))) rd_mux = cyc_shadow[w];
                    if (csr_addr == 8'(CSR_INTV_BASE + 8'(w)))        rd_mux = intv[w];
                end
            end
        endcase
    end

    // Read data is sampled before any same-cycle write lands, so a read sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_rd_ready <= 1'b0;
            csr_rdata    <= '0;
        end else begin
            csr_rd_ready <= csr_rd_valid;
            if (csr_rd_valid) csr_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_vx_timeit_unit.sv
// Self-checking bench for vx_timeit_unit: directed scenarios plus randomized traffic against a behavioural model.
// Works with or without TIMEIT_OVF_IRQ_EN defined.
module tb_vx_timeit_unit;

    localparam int NW = 4;
    localparam int CW = 3;
`ifdef TIMEIT_OVF_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmt_valid;
    logic [CW-1:0] cmt_size;
    logic [NW-1:0] timeit_active;
    logic          timeit_enable;
    logic [31:0]   timeit_start_addr;
    logic [31:0]   timeit_end_addr;
    logic          csr_wr_valid;
    logic          csr_rd_valid;
    logic [7:0]    csr_addr;
    logic [31:0]   csr_wdata;
    logic          csr_rd_ready;
    logic [31:0]   csr_rdata;
    logic [1:0]    dbg_state;
`ifdef TIMEIT_OVF_IRQ_EN
    logic          timeit_ovf_irq;
`endif

    always #5 clk = ~clk;

    vx_timeit_unit #(
        .CORE_ID   (0),
        .NUM_WARPS (NW),
        .CSIZE_W   (CW),
        .CNT_W     (64)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmt_valid         (cmt_valid),
        .cmt_size          (cmt_size),
        .timeit_active     (timeit_active),
        .timeit_enable     (timeit_enable),
        .timeit_start_addr (timeit_start_addr),
        .timeit_end_addr   (timeit_end_addr),
        .csr_wr_valid      (csr_wr_valid),
        .csr_rd_valid      (csr_rd_valid),
        .csr_addr          (csr_addr),
        .csr_wdata         (csr_wdata),
        .csr_rd_ready      (csr_rd_ready),
        .csr_rdata         (csr_rdata),
`ifdef TIMEIT_OVF_IRQ_EN
        .timeit_ovf_irq    (timeit_ovf_irq),
`endif
        .dbg_state         (dbg_state)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: 0=OFF, 1=ARMED, 2=RUNNING.
    int          m_state;
    logic [31:0] m_start, m_end;
    logic [63:0] m_instr;
    logic [31:0] m_ishadow;
    logic [63:0] m_cyc[NW];
    logic [31:0] m_cshadow[NW];
    logic [31:0] m_intv[NW];
    logic [NW-1:0] m_prev;
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_start = '0; m_end = '0; m_instr = '0; m_ishadow = '0;
        m_prev = '0; m_ovf = 1'b0;
        for (int w = 0; w < NW; w++) begin
            m_cyc[w] = '0; m_cshadow[w] = '0; m_intv[w] = '0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a, input logic [NW-1:0] act);
        logic [31:0] v;
        int idx;
        v = '0;
        idx = int'(a);
        if (idx == 0) v = 32'(m_state != 0);
        else if (idx == 1) v = m_start;
        else if (idx == 2) v = m_end;
        else if (idx == 3) v = 32'(act) | (32'(m_state) << 16) | (32'(OVF_EN && m_ovf) << 24);
        else if (idx == 4) v = m_instr[31:0];
        else if (idx == 5) v = m_ishadow;
        else if (idx >= 16 && idx < 16 + 2 * NW) begin
            if (idx % 2 == 0) v = m_cyc[(idx - 16) / 2][31:0];
            else              v = m_cshadow[(idx - 16) / 2];
        end else if (idx >= 48 && idx < 48 + NW) v = m_intv[idx - 48];
        return v;
    endfunction

    // One clock of the model: reads latch shadows from current values, counters
    // count under the current state, a CSR write replaces that cycle's increment,
    // and clear overrides everything except the FSM.
    task automatic model_step(input bit wr, input bit rd, input logic [7:0] a, input logic [31:0] wd,
                              input logic [NW-1:0] act, input bit cv, input logic [CW-1:0] cs);
        bit          run;
        bit          wrapped;
        int          idx;
        int          n_state;
        logic [64:0] sum;
        logic [63:0] old_cyc[NW];
        logic [63:0] old_instr;
        run = (m_state != 0);
        wrapped = 1'b0;
        idx = int'(a);
        old_instr = m_instr;
        for (int w = 0; w < NW; w++) old_cyc[w] = m_cyc[w];

        if (rd && idx == 4) m_ishadow = m_instr[63:32];
        if (rd && idx >= 16 && idx < 16 + 2 * NW && idx % 2 == 0) m_cshadow[(idx - 16) / 2] = m_cyc[(idx - 16) / 2][63:32];

        for (int w = 0; w < NW; w++) begin
            if (run && act[w]) begin
                if (m_cyc[w] == 64'hFFFF_FFFF_FFFF_FFFF) wrapped = 1'b1;
                m_cyc[w] = m_cyc[w] + 64'd1;
            end
            if (run && m_prev[w] && !act[w] && m_intv[w] != 32'hFFFF_FFFF) m_intv[w] = m_intv[w] + 32'd1;
        end
        m_prev = act;
        if (cv && m_state == 2) begin
            sum = {1'b0, m_instr} + 65'(cs);
            if (sum[64]) wrapped = 1'b1;
            m_instr = sum[63:0];
        end

        if (wr) begin
            if (idx == 1) m_start = wd;
            else if (idx == 2) m_end = wd;
            else if (idx == 4) m_instr = {old_instr[63:32], wd};
            else if (idx == 5) m_instr = {wd, old_instr[31:0]};
            else if (idx >= 16 && idx < 16 + 2 * NW) begin
                if (idx % 2 == 0) m_cyc[(idx - 16) / 2] = {old_cyc[(idx - 16) / 2][63:32], wd};
                else              m_cyc[(idx - 16) / 2] = {wd, old_cyc[(idx - 16) / 2][31:0]};
            end else if (idx >= 48 && idx < 48 + NW) m_intv[idx - 48] = wd;
        end
        if (wrapped) m_ovf = 1'b1;

        if (wr && idx == 0 && wd[1]) begin
            m_instr = '0; m_ishadow = '0; m_ovf = 1'b0;
            for (int w = 0; w < NW; w++) begin
                m_cyc[w] = '0; m_cshadow[w] = '0; m_intv[w] = '0;
            end
        end

        n_state = m_state;
        if (m_state == 1 && act != 0) n_state = 2;
        else if (m_state == 2 && act == 0) n_state = 1;
        if (wr && idx == 0) begin
            if (!wd[0]) n_state = 0;
            else if (m_state == 0) n_state = 1;
        end
        m_state = n_state;
    endtask

    task automatic cycle(input bit wr, input bit rd, input logic [7:0] a, input logic [31:0] wd,
                         input logic [NW-1:0] act, input bit cv, input logic [CW-1:0] cs);
        logic [31:0] exp;
        csr_wr_valid = wr; csr_rd_valid = rd; csr_addr = a; csr_wdata = wd;
        timeit_active = act; cmt_valid = cv; cmt_size = cs;
        if (rd) exp_q.push_back(model_read(a, act));
        model_step(wr, rd, a, wd, act, cv, cs);
        @(posedge clk);
        #1;
        check_eq("rd_ready", csr_rd_ready, rd);
        if (rd && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_eq($sformatf("rdata@%02h", a), csr_rdata, exp);
        end
        check_eq("timeit_enable", timeit_enable, m_state != 0);
        check_eq("state", dbg_state, 64'(m_state));
        check_eq("start_addr", timeit_start_addr, m_start);
        check_eq("end_addr", timeit_end_addr, m_end);
`ifdef TIMEIT_OVF_IRQ_EN
        check_eq("ovf_irq", timeit_ovf_irq, m_ovf);
`endif
    endtask

    task automatic wr_csr(input logic [7:0] a, input logic [31:0] d, input logic [NW-1:0] act);
        cycle(1'b1, 1'b0, a, d, act, 1'b0, '0);
    endtask

    task automatic rd_csr(input logic [7:0] a, input logic [NW-1:0] act);
        cycle(1'b0, 1'b1, a, '0, act, 1'b0, '0);
    endtask

    task automatic idle(input logic [NW-1:0] act, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, act, 1'b0, '0);
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 8'($urandom_range(0, 5));
            1, 2, 3: return 8'(8'h10 + 8'($urandom_range(0, 2 * NW - 1)));
            4, 5:    return 8'(8'h30 + 8'($urandom_range(0, NW - 1)));
            6:       return 8'h03;
            7:       return 8'h05;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [NW-1:0] act;
        logic [7:0]    a;
        int            r;

        reset = 1'b0; cmt_valid = 1'b0; cmt_size = '0; timeit_active = '0;
        csr_wr_valid = 1'b0; csr_rd_valid = 1'b0; csr_addr = '0; csr_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_enable", timeit_enable, 1'b0);
        check_eq("rst_rd_ready", csr_rd_ready, 1'b0);
        check_eq("rst_rdata", csr_rdata, 32'h0);
        check_eq("rst_state", dbg_state, 2'd0);
        #2 reset = 1'b1;

        // Enable, program the window, one 25-cycle interval on warp 1.
        wr_csr(8'h00, 32'h1, '0);
        check_eq("enable_after_ctrl", timeit_enable, 1'b1);
        wr_csr(8'h01, 32'h8000_0010, '0);
        wr_csr(8'h02, 32'h8000_0040, '0);
        check_eq("start_const", timeit_start_addr, 32'h8000_0010);
        check_eq("end_const", timeit_end_addr, 32'h8000_0040);
        idle(4'b0010, 25);
        idle(4'b0000, 1);
        rd_csr(8'h12, '0); check_eq("cyc1_25", csr_rdata, 32'd25);
        rd_csr(8'h31, '0); check_eq("intv1_1", csr_rdata, 32'd1);
        rd_csr(8'h10, '0); check_eq("cyc0_0", csr_rdata, 32'd0);
        rd_csr(8'h03, '0); check_eq("status_armed", csr_rdata, 32'h0001_0000);

        // Instruction count: 10 valid commits of 4, 3 invalid ones.
        idle(4'b0001, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, '0, 4'b0001, 1'b1, 3'd4);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b0, '0, '0, 4'b0001, 1'b0, 3'd4);
        idle(4'b0000, 1);
        rd_csr(8'h04, '0); check_eq("instr_40", csr_rdata, 32'd40);

        // Clear colliding with an increment.
        idle(4'b0001, 2);
        cycle(1'b1, 1'b0, 8'h00, 32'h3, 4'b0001, 1'b1, 3'd5);
        rd_csr(8'h10, 4'b0001); check_eq("clr_cyc0", csr_rdata, 32'd0);
        check_eq("clr_keeps_enable", timeit_enable, 1'b1);
        rd_csr(8'h04, 4'b0001); check_eq("clr_instr", csr_rdata, 32'd0);
        idle(4'b0000, 1);

        // Torn-free 64-bit read.
        wr_csr(8'h10, 32'hFFFF_FFFE, '0);
        wr_csr(8'h11, 32'h0, '0);
        rd_csr(8'h10, 4'b0001); check_eq("torn_lo", csr_rdata, 32'hFFFF_FFFE);
        idle(4'b0001, 2);
        rd_csr(8'h11, 4'b0001); check_eq("torn_hi_shadow", csr_rdata, 32'h0);
        rd_csr(8'h10, '0);
        rd_csr(8'h11, '0); check_eq("hi_after_carry", csr_rdata, 32'h1);

        // INTV saturation and CYC wrap.
        wr_csr(8'h32, 32'hFFFF_FFFF, '0);
        idle(4'b0100, 1);
        idle(4'b0000, 1);
        rd_csr(8'h32, '0); check_eq("intv2_sat", csr_rdata, 32'hFFFF_FFFF);
        wr_csr(8'h16, 32'hFFFF_FFFF, '0);
        wr_csr(8'h17, 32'hFFFF_FFFF, '0);
        idle(4'b1000, 1);
        idle(4'b0000, 1);
        rd_csr(8'h16, '0); check_eq("cyc3_wrap_lo", csr_rdata, 32'h0);
        rd_csr(8'h17, '0); check_eq("cyc3_wrap_hi", csr_rdata, 32'h0);
        wr_csr(8'h00, 32'h3, '0);

        // INSTR wrap from 2^64-2 by 4.
        wr_csr(8'h04, 32'hFFFF_FFFE, '0);
        wr_csr(8'h05, 32'hFFFF_FFFF, '0);
        idle(4'b0001, 1);
        cycle(1'b0, 1'b0, '0, '0, 4'b0001, 1'b1, 3'd4);
        idle(4'b0000, 2);
        rd_csr(8'h04, '0); check_eq("instr_wrap_lo", csr_rdata, 32'd2);
        rd_csr(8'h05, '0); check_eq("instr_wrap_hi", csr_rdata, 32'd0);
        wr_csr(8'h00, 32'h3, '0);

        // Disable while warp 2 is active: counters freeze, no interval counted.
        idle(4'b0100, 5);
        wr_csr(8'h00, 32'h0, 4'b0100);
        idle(4'b0100, 1);
        idle(4'b0000, 2);
        rd_csr(8'h14, '0); check_eq("cyc2_frozen", csr_rdata, 32'd6);
        rd_csr(8'h32, '0); check_eq("intv2_none", csr_rdata, 32'd0);
        rd_csr(8'h03, '0); check_eq("status_off", csr_rdata, 32'h0);

        // Randomized traffic.
        wr_csr(8'h00, 32'h1, '0);
        act = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) act = NW'($urandom);
            r = $urandom_range(0, 99);
            a = pick_addr();
            if (r < 40) begin
                cycle(1'b0, 1'b1, a, '0, act, 1'($urandom), CW'($urandom));
            end else if (r < 47) begin
                if (a == 8'h00) a = 8'h01;
                cycle(1'b1, 1'b0, a, $urandom, act, 1'($urandom), CW'($urandom));
            end else if (r < 50) begin
                cycle(1'b1, 1'b0, 8'h00, {30'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)},
                      act, 1'($urandom), CW'($urandom));
            end else if (r < 53) begin
                if (a == 8'h00) a = 8'h02;
                cycle(1'b1, 1'b1, a, $urandom, act, 1'($urandom), CW'($urandom));
            end else begin
                cycle(1'b0, 1'b0, '0, '0, act, 1'($urandom), CW'($urandom));
            end
        end

        // Asynchronous reset in the middle of RUNNING.
        wr_csr(8'h00, 32'h1, 4'b0011);
        idle(4'b0011, 2);
        wr_csr(8'h01, 32'h1234_5678, 4'b0011);
        rd_csr(8'h01, 4'b0011);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_enable", timeit_enable, 1'b0);
        check_eq("arst_start", timeit_start_addr, 32'h0);
        check_eq("arst_end", timeit_end_addr, 32'h0);
        check_eq("arst_rd_ready", csr_rd_ready, 1'b0);
        check_eq("arst_rdata", csr_rdata, 32'h0);
        check_eq("arst_state", dbg_state, 2'd0);
        model_reset();
        timeit_active = '0; csr_rd_valid = 1'b0; csr_wr_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        rd_csr(8'h03, '0); check_eq("arst_status", csr_rdata, 32'h0);
        rd_csr(8'h12, '0); check_eq("arst_cyc1", csr_rdata, 32'h0);
        idle('0, 2);

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
